// File: rtl/dvi_scanout_pkg.sv
// Shared types and sizing helpers for the DVI scanout controller.
package dvi_scanout_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic int frame_px(input int h, input int v);
    return h * v;
  endfunction

  function automatic int frame_cnt_w(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

  function automatic int credit_cnt_w(input int depth);
    return $clog2(depth * 2 + 1);
  endfunction

endpackage

// File: rtl/dvi_scanout_ctrl_fifo.sv
// Show-ahead synchronous FIFO: head word is visible on rdata_o whenever not empty.
module sync_fifo_showahead #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped rather than overwriting the head.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dvi_scanout_ctrl.sv
// Scanout scheduler: burst-fetches a linear framebuffer into a pixel FIFO and
// feeds one pixel per rgb_rdy, resyncing on frame_sync and flagging underflow.
module dvi_scanout_ctrl
  import dvi_scanout_pkg::*;
#(
  parameter int               H_ACTIVE   = 640,
  parameter int               V_ACTIVE   = 480,
  parameter int               ADDR_W     = 20,
  parameter int               BURST_LEN  = 8,
  parameter int               FIFO_DEPTH = 32,
  parameter logic [PIX_W-1:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              frame_sync,
  output logic              rd_req_vld,
  input  logic              rd_req_rdy,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_data_vld,
  input  logic [PIX_W-1:0]  rd_data,
  input  logic              rgb_rdy,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              underflow,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME = frame_px(H_ACTIVE, V_ACTIVE);
  localparam int FW    = frame_cnt_w(H_ACTIVE, V_ACTIVE);
  localparam int CW    = credit_cnt_w(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FW-1:0]     fetched_q, fetched_d, consumed_q, consumed_d;
  logic [CW-1:0]     inflight_q, inflight_d, discard_q, discard_d;
  logic              underflow_q, underflow_d, frame_err_q, frame_err_d;

  logic              fifo_flush, fifo_push, fifo_pop;
  logic [PIX_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;

  logic run, resync, req_fire, beat_disc, beat_acc, infl_dec;

  sync_fifo_showahead #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (rd_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign run       = (state_q == ST_RUN);
  assign resync    = en && frame_sync && (state_q == ST_ARMED || run);
  assign req_fire  = rd_req_vld && rd_req_rdy;
  assign beat_disc = rd_data_vld && (discard_q != '0);
  assign beat_acc  = rd_data_vld && (discard_q == '0);
  assign infl_dec  = beat_acc && (inflight_q != '0);

  // Discard is also held under FIFO_DEPTH before issuing so that back-to-back
  // resyncs can never push the outstanding-beat total past 2*FIFO_DEPTH.
  assign rd_req_vld = run
                   && (32'(fetched_q) < 32'(FRAME))
                   && (32'(discard_q) <= 32'(FIFO_DEPTH))
                   && (32'(fifo_level) + 32'(inflight_q) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH));
  assign rd_req_addr = addr_q;

  assign busy      = run;
  assign underflow = underflow_q;
  assign frame_err = frame_err_q;
  assign {r, g, b} = (run && !fifo_empty) ? fifo_head : BORDER_RGB;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fetched_d   = fetched_q;
    consumed_d  = consumed_q;
    inflight_d  = inflight_q - CW'(infl_dec) + (req_fire ? CW'(BURST_LEN) : '0);
    discard_d   = discard_q - CW'(beat_disc);
    underflow_d = underflow_q;
    frame_err_d = frame_err_q;
    fifo_flush  = !en || resync;
    fifo_push   = beat_acc && run && en && !resync;
    fifo_pop    = 1'b0;

    if (req_fire) begin
      addr_d    = addr_q + ADDR_W'(BURST_LEN);
      fetched_d = fetched_q + FW'(BURST_LEN);
    end

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_ARMED;
          underflow_d = 1'b0;
          frame_err_d = 1'b0;
        end
        ST_ARMED: if (frame_sync) state_d = ST_RUN;
        ST_RUN: begin
          if (frame_sync) begin
            if (consumed_q != FW'(FRAME)) frame_err_d = 1'b1;
          end else if (rgb_rdy) begin
            consumed_d = consumed_q + FW'(1);
            fifo_pop   = !fifo_empty;
            if (fifo_empty) underflow_d = 1'b1;
            if (consumed_q == FW'(FRAME - 1)) state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Everything still in flight (including a burst accepted this cycle) is
    // converted into beats to drop before the new frame's data.
    if (resync) begin
      addr_d     = fb_base;
      fetched_d  = '0;
      consumed_d = '0;
      discard_d  = discard_d + inflight_d;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      fetched_q   <= '0;
      consumed_q  <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fetched_q   <= fetched_d;
      consumed_q  <= consumed_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_dvi_scanout_ctrl.sv
// Directed bench: small 8x4 frame, latency-5 memory model returning {4'hA, addr}.
module tb_dvi_scanout_ctrl;

  localparam int         AW     = 20;
  localparam int         BURST  = 8;
  localparam int         LAT    = 5;
  localparam logic [23:0] BORDER = 24'h5A5A5A;

  logic          clk, rst, en, frame_sync, rd_req_vld, rd_req_rdy, rd_data_vld, rgb_rdy;
  logic [AW-1:0] fb_base, rd_req_addr;
  logic [23:0]   rd_data, pix;
  logic [7:0]    r, g, b;
  logic          underflow, frame_err, busy, resp_stall;

  int n_chk, n_fail, cyc, last_due, max_out;

  typedef struct packed { logic [AW-1:0] addr; int due; } beat_t;
  beat_t         bq[$];
  logic [AW-1:0] req_log[$];

  assign pix = {r, g, b};

  dvi_scanout_ctrl #(
    .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(AW), .BURST_LEN(BURST),
    .FIFO_DEPTH(32), .BORDER_RGB(BORDER)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fb_base(fb_base), .frame_sync(frame_sync),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_addr(rd_req_addr),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .rgb_rdy(rgb_rdy),
    .r(r), .g(g), .b(b), .underflow(underflow), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request monitor: a handshake seen at negedge is taken at the next posedge.
  initial begin
    int    d;
    beat_t bt;
    last_due = 0;
    max_out  = 0;
    forever begin
      @(negedge clk);
      if (rd_req_vld && rd_req_rdy && !rst) begin
        req_log.push_back(rd_req_addr);
        for (int k = 0; k < BURST; k++) begin
          d = cyc + 1 + LAT + k;
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          bt.addr  = rd_req_addr + AW'(k);
          bt.due   = d;
          bq.push_back(bt);
        end
        if (bq.size() > max_out) max_out = bq.size();
      end
    end
  end

  // In-order responder, one beat per cycle, no backpressure.
  initial begin
    rd_data_vld = 1'b0;
    rd_data     = '0;
    cyc         = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!resp_stall && bq.size() > 0 && bq[0].due <= cyc) begin
        rd_data_vld = 1'b1;
        rd_data     = {4'hA, bq[0].addr};
        void'(bq.pop_front());
      end else begin
        rd_data_vld = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync_pulse(input logic [AW-1:0] base);
    fb_base    = base;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic consume(input int n, input logic [AW-1:0] base, input string tag);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a       = base + AW'(i);
      rgb_rdy = 1'b1;
      chk(tag, 32'(pix), 32'({4'hA, a}));
      tick();
    end
    rgb_rdy = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; frame_sync = 1'b0; fb_base = '0;
    rd_req_rdy = 1'b0; rgb_rdy = 1'b0; resp_stall = 1'b0;
    tick(2);
    chk("rst_vld",   32'(rd_req_vld),  0);
    chk("rst_addr",  32'(rd_req_addr), 0);
    chk("rst_busy",  32'(busy),        0);
    chk("rst_uflow", 32'(underflow),   0);
    chk("rst_ferr",  32'(frame_err),   0);
    chk("rst_pix",   32'(pix),         32'(BORDER));
    rst = 1'b0;

    // Normal frame at 0x100
    en = 1'b1; rd_req_rdy = 1'b1;
    tick();
    chk("armed_busy", 32'(busy), 0);
    sync_pulse(20'h100);
    chk("run_busy",  32'(busy),        1);
    chk("run_vld",   32'(rd_req_vld),  1);
    chk("run_addr",  32'(rd_req_addr), 32'h100);
    chk("empty_pix", 32'(pix),         32'(BORDER));
    tick(45);
    chk("fetch_done_vld", 32'(rd_req_vld), 0);
    chk("f1_nreq", 32'(req_log.size()), 4);
    for (int i = 0; i < 4; i++) chk("f1_req_addr", 32'(req_log[i]), 32'h100 + 32'(8 * i));
    consume(32, 20'h100, "f1_pix");
    chk("f1_end_busy",  32'(busy),      0);
    chk("f1_end_uflow", 32'(underflow), 0);
    chk("f1_end_ferr",  32'(frame_err), 0);

    // Request backpressure, then response stall and underflow
    rd_req_rdy = 1'b0;
    sync_pulse(20'h200);
    tick(20);
    chk("stall_addr", 32'(rd_req_addr),    32'h200);
    chk("stall_vld",  32'(rd_req_vld),     1);
    chk("stall_nreq", 32'(req_log.size()), 4);
    resp_stall = 1'b1; rd_req_rdy = 1'b1;
    tick(10);
    chk("credit_nreq",   32'(req_log.size()), 8);
    chk("uflow_pre",     32'(underflow),      0);
    rgb_rdy = 1'b1;
    chk("uflow_pix", 32'(pix), 32'(BORDER));
    tick();
    rgb_rdy = 1'b0;
    chk("uflow_set", 32'(underflow), 1);
    resp_stall = 1'b0;
    tick(45);
    chk("max_outstanding", 32'(max_out), 32);
    for (int i = 0; i < 4; i++) chk("f2_req_addr", 32'(req_log[4 + i]), 32'h200 + 32'(8 * i));
    consume(31, 20'h200, "f2_pix");
    chk("f2_end_busy",   32'(busy),      0);
    chk("uflow_sticky",  32'(underflow), 1);

    // Resync mid-frame with two bursts outstanding
    rd_req_rdy = 1'b0; resp_stall = 1'b1;
    sync_pulse(20'h300);
    chk("ferr_pre", 32'(frame_err), 0);
    rd_req_rdy = 1'b1;
    tick(2);
    rd_req_rdy = 1'b0;
    chk("f3_nreq",  32'(req_log.size()), 10);
    chk("f3_req0",  32'(req_log[8]),     32'h300);
    chk("f3_req1",  32'(req_log[9]),     32'h308);
    sync_pulse(20'h400);
    chk("ferr_set",     32'(frame_err),   1);
    chk("resync_addr",  32'(rd_req_addr), 32'h400);
    chk("resync_busy",  32'(busy),        1);
    resp_stall = 1'b0; rd_req_rdy = 1'b1;
    tick(80);
    chk("f3_req_new", 32'(req_log[10]), 32'h400);
    consume(32, 20'h400, "f3_pix");
    chk("f3_end_busy", 32'(busy), 0);

    // en=0 mid-frame, then re-arm
    sync_pulse(20'h500);
    tick(50);
    consume(4, 20'h500, "f4_pix");
    en = 1'b0;
    tick();
    chk("dis_busy",  32'(busy),       0);
    chk("dis_vld",   32'(rd_req_vld), 0);
    chk("dis_pix",   32'(pix),        32'(BORDER));
    chk("dis_uflow", 32'(underflow),  1);
    chk("dis_ferr",  32'(frame_err),  1);
    tick(3);
    en = 1'b1;
    tick();
    chk("rearm_uflow", 32'(underflow), 0);
    chk("rearm_ferr",  32'(frame_err), 0);
    tick(10);
    chk("rearm_wait_busy", 32'(busy),       0);
    chk("rearm_wait_vld",  32'(rd_req_vld), 0);
    sync_pulse(20'h600);
    tick(50);
    consume(32, 20'h600, "f5_pix");
    chk("f5_end_busy", 32'(busy), 0);

    // Reset mid-burst with underflow set
    resp_stall = 1'b1;
    sync_pulse(20'h700);
    rgb_rdy = 1'b1;
    tick();
    rgb_rdy = 1'b0;
    resp_stall = 1'b0;
    tick(8);
    chk("mid_busy",  32'(busy),      1);
    chk("mid_uflow", 32'(underflow), 1);
    rst = 1'b1;
    tick();
    chk("mrst_vld",   32'(rd_req_vld),  0);
    chk("mrst_addr",  32'(rd_req_addr), 0);
    chk("mrst_busy",  32'(busy),        0);
    chk("mrst_uflow", 32'(underflow),   0);
    chk("mrst_ferr",  32'(frame_err),   0);
    chk("mrst_pix",   32'(pix),         32'(BORDER));
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_scanout_ctrl.md
Name: dvi_scanout_ctrl

Overview:
- Pixel-clock-domain scanout scheduler that feeds the r/g/b/rgb_rdy interface of dvi_tx_parallel from a linear framebuffer.
- Issues burst read requests to a memory port, buffers response pixels in a small show-ahead FIFO, and pops one pixel per rgb_rdy.
- Resynchronises to frame boundaries, detects underflow and substitutes a border colour.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 20, pixel-address width
- BURST_LEN, 8, beats per read request; power of two, at most FIFO_DEPTH/2
- FIFO_DEPTH, 32, pixel FIFO entries; power of two
- BORDER_RGB, 24'h000000, colour driven on underflow or when not running

Ports:
- clk, input, 1, pixel clock (clk_pix domain)
- rst, input, 1, reset; synchronous, active-high
- en, input, 1, scanout enable
- fb_base, input, ADDR_W, framebuffer base pixel address; sampled on frame_sync
- frame_sync, input, 1, one-cycle pulse at the start of vertical blanking
- rd_req_vld, output, 1, read request valid
- rd_req_rdy, input, 1, read request accepted
- rd_req_addr, output, ADDR_W, first pixel address of the burst
- rd_data_vld, input, 1, response beat valid; in order; no backpressure
- rd_data, input, 24, response pixel {r,g,b}
- rgb_rdy, input, 1, dvi_tx_parallel consumes r/g/b this cycle
- r, g, b, output, 8 each, pixel to the encoder
- underflow, output, 1, sticky: rgb_rdy arrived with the FIFO empty while in RUN
- frame_err, output, 1, sticky: frame_sync arrived before H_ACTIVE*V_ACTIVE pixels were consumed
- busy, output, 1, state is RUN

Behaviour:
- Reset values:
  - state IDLE
  - rd_req_vld=0, rd_req_addr=0
  - underflow=0, frame_err=0, busy=0
  - FIFO empty, all counters 0
  - r/g/b = BORDER_RGB
- FSM states and transitions:
  - IDLE -> ARMED when en=1.
  - ARMED -> RUN on frame_sync.
  - RUN -> ARMED when consumed count reaches H_ACTIVE*V_ACTIVE.
  - Any state -> IDLE when en=0, on the next cycle.
- Entering RUN, and every frame_sync:
  - Flush the FIFO.
  - Load addr <= fb_base; clear fetched and consumed counters.
  - Set discard <= number of response beats still outstanding (outstanding requests * BURST_LEN).
  - While discard > 0, response beats are dropped and discard decrements.
- frame_sync in RUN with consumed != H_ACTIVE*V_ACTIVE sets frame_err and resyncs as above. frame_sync in IDLE is ignored.
- Request issue rule:
  - In RUN, assert rd_req_vld when fetched < H_ACTIVE*V_ACTIVE and (FIFO free - inflight beats) >= BURST_LEN.
  - rd_req_addr is held stable while vld=1 and rdy=0.
  - On vld&&rdy: addr += BURST_LEN (modulo 2^ADDR_W, wraps silently), fetched += BURST_LEN, inflight += BURST_LEN.
  - inflight decrements on each accepted (non-discarded) beat.
  - This credit rule guarantees no FIFO overflow. A beat arriving with the FIFO full is a protocol violation; it is dropped, not written.
- Pixel output:
  - In RUN with the FIFO non-empty, r/g/b = FIFO head (combinational from the registered head). Otherwise r/g/b = BORDER_RGB.
  - rgb_rdy in RUN pops the FIFO if non-empty and increments consumed.
  - rgb_rdy in RUN with the FIFO empty sets underflow, drives border, and still increments consumed, so the frame length is preserved and the image shifts until the next resync.
  - rgb_rdy outside RUN has no effect.
- Simultaneous events in one cycle:
  - Pop and push in the same cycle: occupancy unchanged.
  - frame_sync together with rgb_rdy: the resync wins and the pop is ignored.
  - en=0 together with any event: goes to IDLE, flushes, and leaves sticky flags intact.
  - Sticky flags clear only on rst or on IDLE -> ARMED.
- Counter widths: consumed and fetched use clog2(H_ACTIVE*V_ACTIVE+1) bits; inflight and discard use clog2(FIFO_DEPTH*2+1) bits.

Decomposition:
- Package dvi_scanout_pkg:
  - state encoding (IDLE, ARMED, RUN)
  - PIX_W=24
  - localparam helper for frame pixel count and counter widths
- One sub-module, sync_fifo_showahead: parameterised width and depth, push/pop/flush, with full, empty and level outputs. The credit logic uses level.

Test Plan:
- Reset, en=1, frame_sync, rd_req_rdy=1, responses after 5 cycles, fb_base=0x100 -> requests at 0x100, 0x108, 0x110…; r/g/b match rd_data order; no underflow across a full 640x480 frame; busy drops after pixel 307200.
- Hold rd_req_rdy=0 for 20 cycles -> rd_req_addr stable; at most FIFO_DEPTH/BURST_LEN=4 requests outstanding; FIFO never exceeds 32 entries.
- Stall responses until FIFO empty, then pulse rgb_rdy -> r/g/b=BORDER_RGB, underflow=1 and stays 1; consumed still increments.
- frame_sync mid-frame with 2 requests in flight -> frame_err=1, FIFO flushed, next 16 beats discarded, first displayed pixel = data for fb_base.
- en=0 mid-frame -> IDLE next cycle, rd_req_vld=0, r/g/b=border; re-enable -> waits in ARMED until frame_sync, flags cleared.
- rst asserted mid-burst -> all outputs at reset values next cycle.
